// File: rtl/irq_inject_ctrl.sv
// irq_inject_ctrl: sequences external interrupt requests into a safe decode slot
// Ports:
//   clk_i, reset_b_i     clock, synchronous active-low reset
//   irq_en_i, irq_req_i  global enable, level-sensitive request
//   id_valid_i .. exception_i  decode-stage status used to find a safe slot
//   irq_out_o            IRQ to the ID control unit (combinational, PENDING only)
//   irq_ack_o            one-cycle registered acknowledge after injection
//   pending_o, in_service_o  state decodes
//   irq_count_o          saturating count of injected interrupts
//   starve_err_o         sticky: a request waited longer than MAX_WAIT cycles
module irq_inject_ctrl #(
  parameter int HOLDOFF  = 4,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk_i,
  input  logic             reset_b_i,
  input  logic             irq_en_i,
  input  logic             irq_req_i,
  input  logic             id_valid_i,
  input  logic             id_pc31_i,
  input  logic             bubble_i,
  input  logic             id_flush_i,
  input  logic             jflush_i,
  input  logic             exception_i,
  output logic             irq_out_o,
  output logic             irq_ack_o,
  output logic             pending_o,
  output logic             in_service_o,
  output logic [CNT_W-1:0] irq_count_o,
  output logic             starve_err_o
);
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [HW-1:0] HLD = HW'(HOLDOFF - 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT + 1);
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_SVC, S_HOLD} state_e;
  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ack_q, ack_d, starve_q, starve_d, safe;
  assign safe = id_valid_i & ~id_pc31_i & ~bubble_i & ~id_flush_i & ~jflush_i & ~exception_i;
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    starve_d  = starve_q;
    irq_out_o = 1'b0;
    case (state_q)
      S_IDLE: if (irq_en_i & irq_req_i & ~id_pc31_i) begin
        state_d = S_PEND;
        wait_d  = '0;
      end
      S_PEND: begin
        // injection wins over a request dropping in the same cycle
        irq_out_o = safe & reset_b_i;
        if (safe) begin
          state_d = S_SVC;
          ack_d   = 1'b1;
          cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        end else if (~irq_req_i | ~irq_en_i) begin
          state_d = S_IDLE;
        end else begin
          wait_d   = wait_q == WMAX ? wait_q : wait_q + WW'(1);
          starve_d = starve_q | (wait_d == WMAX);
        end
      end
      // first user-mode instruction decoded marks the handler's return
      S_SVC: if (id_valid_i & ~id_pc31_i) begin
        state_d = S_HOLD;
        hold_d  = HLD;
      end
      S_HOLD: begin
        state_d = hold_q == '0 ? S_IDLE : S_HOLD;
        hold_d  = hold_q == '0 ? hold_q : hold_q - HW'(1);
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_b_i) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      wait_q   <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      starve_q <= starve_d;
    end
  end
  assign irq_ack_o    = ack_q;
  assign pending_o    = state_q == S_PEND;
  assign in_service_o = state_q == S_SVC;
  assign irq_count_o  = cnt_q;
  assign starve_err_o = starve_q;
endmodule

// File: tb/tb_irq_inject_ctrl.sv
// tb_irq_inject_ctrl: table-driven scoreboard bench for irq_inject_ctrl
module tb_irq_inject_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_b, irq_en, irq_req, id_valid, id_pc31, bubble, id_flush, jflush, exception;
  logic irq_out, irq_ack, pending, in_service, starve_err;
  logic [15:0] irq_count;
  irq_inject_ctrl #(.HOLDOFF(4), .CNT_W(16), .MAX_WAIT(3)) dut (
    .clk_i(clk), .reset_b_i(reset_b), .irq_en_i(irq_en), .irq_req_i(irq_req),
    .id_valid_i(id_valid), .id_pc31_i(id_pc31), .bubble_i(bubble), .id_flush_i(id_flush),
    .jflush_i(jflush), .exception_i(exception), .irq_out_o(irq_out), .irq_ack_o(irq_ack),
    .pending_o(pending), .in_service_o(in_service), .irq_count_o(irq_count),
    .starve_err_o(starve_err)
  );
  // in: {reset_b, en, req, valid, pc31, bubble, flush, jflush, exception}
  // o:  {irq_out, irq_ack, pending, in_service} as seen during the cycle
  typedef struct packed {
    logic [8:0]  in;
    logic [3:0]  o;
    logic [15:0] cnt;
    logic        st;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t e;
  logic [20:0] got;
  int checks = 0, errors = 0, row = 0;
  function automatic vec_t mk(input logic [8:0] in, input logic [3:0] o, input int c, input logic st);
    vec_t r;
    r.in  = in;
    r.o   = o;
    r.cnt = 16'(c);
    r.st  = st;
    return r;
  endfunction
  task automatic add(input logic [8:0] in, input logic [3:0] o, input int c, input logic st, input int n = 1);
    repeat (n) tbl.push_back(mk(in, o, c, st));
  endtask
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    {reset_b, irq_en, irq_req, id_valid, id_pc31, bubble, id_flush, jflush, exception} = v.in;
    sb.push_back(v);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {irq_out, irq_ack, pending, in_service, irq_count, starve_err};
      checks++;
      if (got !== {e.o, e.cnt, e.st}) begin
        errors++;
        $display("FAIL row %0d: out/ack/pend/svc=%b cnt=%0d starve=%b, required %b cnt=%0d starve=%b",
                 row, got[20:17], got[16:1], got[0], e.o, e.cnt, e.st);
      end
      row++;
    end
  end
  initial begin
    {reset_b, irq_en, irq_req, id_valid, id_pc31, bubble, id_flush, jflush, exception} = '0;
    repeat (2) @(posedge clk);
    // basic injection, service, exit, 4-cycle holdoff with request held
    add(9'b111100000, 4'b0000, 0, 0);
    add(9'b111100000, 4'b1010, 0, 0);
    add(9'b111110000, 4'b0101, 1, 0);
    add(9'b111110000, 4'b0001, 1, 0);
    add(9'b111100000, 4'b0001, 1, 0);
    add(9'b111100000, 4'b0000, 1, 0, 4);
    add(9'b111100000, 4'b0000, 1, 0);
    // unsafe slots: 3 bubbles then jflush, then safe; starvation trips after 4 stalls
    add(9'b111101000, 4'b0010, 1, 0, 3);
    add(9'b111100010, 4'b0010, 1, 0);
    add(9'b111100000, 4'b1010, 1, 1);
    add(9'b111110000, 4'b0101, 2, 1);
    add(9'b111100000, 4'b0001, 2, 1);
    add(9'b111100000, 4'b0000, 2, 1, 5);
    // withdrawal with id_flush
    add(9'b110100100, 4'b0010, 2, 1);
    add(9'b110100000, 4'b0000, 2, 1);
    // exception blocks, then injection while request drops
    add(9'b111100000, 4'b0000, 2, 1);
    add(9'b111100001, 4'b0010, 2, 1);
    add(9'b110100000, 4'b1010, 2, 1);
    add(9'b110110000, 4'b0101, 3, 1);
    add(9'b110000000, 4'b0001, 3, 1);
    add(9'b110100000, 4'b0001, 3, 1);
    add(9'b111100000, 4'b0000, 3, 1, 4);
    // kernel mode and disable block entry; disable withdraws from PENDING
    add(9'b111110000, 4'b0000, 3, 1);
    add(9'b101100000, 4'b0000, 3, 1);
    add(9'b111100000, 4'b0000, 3, 1);
    add(9'b101101000, 4'b0010, 3, 1);
    add(9'b101100000, 4'b0000, 3, 1);
    foreach (tbl[i]) step(tbl[i]);
    // reset for two cycles mid-service
    step(mk(9'b111100000, 4'b0000, 3, 1));
    step(mk(9'b111100000, 4'b1010, 3, 1));
    step(mk(9'b111110000, 4'b0101, 4, 1));
    step(mk(9'b011110000, 4'b0001, 4, 1));
    step(mk(9'b011100000, 4'b0000, 0, 0));
    // reset while PENDING with a safe slot: irq_out held low
    step(mk(9'b111100000, 4'b0000, 0, 0));
    step(mk(9'b011100000, 4'b0010, 0, 0));
    // fresh starvation: sets after 4 stalled PENDING cycles and stays set
    step(mk(9'b111101000, 4'b0000, 0, 0));
    repeat (4) step(mk(9'b111101000, 4'b0010, 0, 0));
    step(mk(9'b111101000, 4'b0010, 0, 1));
    step(mk(9'b111100000, 4'b1010, 0, 1));
    step(mk(9'b111110000, 4'b0101, 1, 1));
    step(mk(9'b100100000, 4'b0001, 1, 1));
    repeat (5) step(mk(9'b100100000, 4'b0000, 1, 1));
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
